// File: rtl/layer_csr_sequencer.sv
// rtl/layer_csr_sequencer.sv - per-layer CSR weight sequencer with spike AER FIFO
module layer_csr_sequencer #(
    parameter int NUM_NEURONS = 40,
    parameter int NUM_STEPS   = 4,
    parameter int CSR_ADDR_W  = 14,
    parameter int VOL_W       = 16,
    parameter int INIT_VOL    = 0,
    parameter int AER_DEPTH   = 8,
    localparam int NW = $clog2(NUM_NEURONS + 1),
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [NW-1:0]         offset_addr,
    input  logic [CSR_ADDR_W-1:0] offset_value,
    output logic [NW-1:0]         vol_addr,
    output logic                  vol_init_wr,
    output logic [VOL_W-1:0]      init_vol,
    output logic                  load_voltage,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic                  w_n_a_valid,
    output logic                  export_voltage,
    input  logic                  spk,
    output logic                  aer_valid,
    output logic [SW+NW-1:0]      aer_data,
    input  logic                  aer_ready,
    output logic                  aer_overflow,
    output logic                  busy,
    output logic                  step_done,
    output logic                  layer_done
);
    localparam int AW = $clog2(AER_DEPTH);
    localparam logic [NW-1:0] LAST_N   = NW'(NUM_NEURONS - 1);
    localparam logic [SW-1:0] LAST_S   = SW'(NUM_STEPS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(AER_DEPTH);

    typedef enum logic [3:0] {
        IDLE, INIT, FETCH0, FETCH1, LOAD, ACCUM, EXPORT, SPKCAP, STEPEND, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         n_q, n_d;
    logic [SW-1:0]         s_q, s_d;
    logic [CSR_ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, addr_q, addr_d;
    logic [SW+NW-1:0]      mem_q [AER_DEPTH];
    logic [SW+NW-1:0]      mem_d [AER_DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, ovf_clr;
    logic                  push, pop, full;

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        s_d            = s_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        addr_d         = addr_q;
        ovf_clr        = 1'b0;
        offset_addr    = '0;
        vol_addr       = '0;
        vol_init_wr    = 1'b0;
        init_vol       = '0;
        load_voltage   = 1'b0;
        csr_addr       = '0;
        w_n_a_valid    = 1'b0;
        export_voltage = 1'b0;
        step_done      = 1'b0;
        layer_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_clr = 1'b1;
                    n_d     = '0;
                    s_d     = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                vol_init_wr = 1'b1;
                init_vol    = VOL_W'(INIT_VOL);
                vol_addr    = n_q;
                if (n_q == LAST_N) begin
                    n_d     = '0;
                    state_d = FETCH0;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            FETCH0: begin
                state_d = FETCH1;
            end
            FETCH1: begin
                lo_d        = offset_value;
                offset_addr = n_q + NW'(1);
                state_d     = LOAD;
            end
            LOAD: begin
                // Branch on the live row pointer; hi_q only holds it from next cycle.
                hi_d         = offset_value;
                load_voltage = 1'b1;
                vol_addr     = n_q;
                addr_d       = lo_q;
                state_d      = (offset_value > lo_q) ? ACCUM : EXPORT;
            end
            ACCUM: begin
                w_n_a_valid = 1'b1;
                csr_addr    = addr_q;
                vol_addr    = n_q;
                addr_d      = addr_q + CSR_ADDR_W'(1);
                if (addr_q == hi_q - CSR_ADDR_W'(1)) begin
                    state_d = EXPORT;
                end
            end
            EXPORT: begin
                export_voltage = 1'b1;
                vol_addr       = n_q;
                state_d        = SPKCAP;
            end
            SPKCAP: begin
                // Next neuron's start pointer is this one's end; fetch only its end.
                if (n_q != LAST_N) begin
                    n_d         = n_q + NW'(1);
                    lo_d        = hi_q;
                    offset_addr = n_q + NW'(2);
                    state_d     = LOAD;
                end else begin
                    state_d = STEPEND;
                end
            end
            STEPEND: begin
                step_done = 1'b1;
                if (s_q != LAST_S) begin
                    s_d     = s_q + SW'(1);
                    n_d     = '0;
                    state_d = FETCH0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                layer_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = (state_q == SPKCAP) && spk;
    assign pop  = aer_valid && aer_ready;
    assign full = (cnt_q == FULL_CNT);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (push) begin
            mem_d[wr_q] = {s_q, n_q};
            wr_d        = wr_q + AW'(1);
            if (!pop) begin
                cnt_d = cnt_q + (AW + 1)'(1);
            end
        end else if (pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            s_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < AER_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            s_q     <= s_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign aer_valid    = (cnt_q != '0);
    assign aer_data     = mem_q[rd_q];
    assign aer_overflow = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule
